// File: rtl/traffic_lamp_monitor_pkg.sv
// Shared types and constants for the traffic lamp monitor: display phase
// encodings, lamp patterns, tracker state and the expected crossing order.
package traffic_lamp_monitor_pkg;

   typedef enum logic [2:0] {
      PH_CG      = 3'd0,
      PH_CY      = 3'd1,
      PH_RH      = 3'd2,
      PH_PG      = 3'd3,
      PH_CRY     = 3'd4,
      PH_INVALID = 3'd7
   } phase_e;

   typedef enum logic {
      ST_SYNC = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   // Lamp vector order: {road_red, road_yellow, road_green, ped_red, ped_green}
   localparam logic [4:0] LAMP_CG  = 5'b00110;
   localparam logic [4:0] LAMP_CY  = 5'b01010;
   localparam logic [4:0] LAMP_RH  = 5'b10010;
   localparam logic [4:0] LAMP_PG  = 5'b10001;
   localparam logic [4:0] LAMP_CRY = 5'b11010;

   // Last position of the six-step crossing cycle
   localparam logic [2:0] POS_LAST = 3'd5;

   // Display expected at a given position of the crossing cycle
   function automatic phase_e exp_phase(input logic [2:0] pos);
      phase_e ph;
      case (pos)
         3'd0:    ph = PH_CG;
         3'd1:    ph = PH_CY;
         3'd2:    ph = PH_RH;
         3'd3:    ph = PH_PG;
         3'd4:    ph = PH_RH;
         3'd5:    ph = PH_CRY;
         default: ph = PH_INVALID;
      endcase
      return ph;
   endfunction

   // Required length in cycles of the display at a given position
   function automatic logic [7:0] exp_len(input logic [2:0] pos,
                                          input logic [7:0] t_long,
                                          input logic [7:0] t_short,
                                          input logic [7:0] t_red);
      logic [7:0] len;
      case (pos)
         3'd0, 3'd3: len = t_long;
         3'd1, 3'd5: len = t_short;
         default:    len = t_red;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// Combinational decode of the sampled lamp vector into a display phase,
// plus detection of pedestrian green overlapping road green or yellow.
module traffic_lamp_decode
   import traffic_lamp_monitor_pkg::*;
(
   input  logic [4:0] i_lamps,
   output logic [2:0] o_phase,
   output logic       o_conflict
);

   phase_e w_dec;

   // Map each legal lamp pattern to its display; everything else is invalid
   always_comb begin
      w_dec = PH_INVALID;
      case (i_lamps)
         LAMP_CG:  w_dec = PH_CG;
         LAMP_CY:  w_dec = PH_CY;
         LAMP_RH:  w_dec = PH_RH;
         LAMP_PG:  w_dec = PH_PG;
         LAMP_CRY: w_dec = PH_CRY;
         default:  w_dec = PH_INVALID;
      endcase
   end

   assign o_phase    = w_dec;
   // ped_green together with road_green or road_yellow
   assign o_conflict = i_lamps[0] & (i_lamps[2] | i_lamps[3]);

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Traffic lamp monitor: samples the lamp drives once, decodes the display,
// tracks the expected crossing order and display lengths, and reports
// conflicts, invalid patterns, order and timing violations.
module traffic_lamp_monitor
   import traffic_lamp_monitor_pkg::*;
#(
   parameter int T_LONG  = 6,
   parameter int T_SHORT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        road_red,
   input  logic        road_yellow,
   input  logic        road_green,
   input  logic        ped_red,
   input  logic        ped_green,
   input  logic        clr_err,
   output logic [2:0]  phase,
   output logic        locked,
   output logic        err_conflict,
   output logic        err_invalid,
   output logic        err_sequence,
   output logic        err_timing,
   output logic [3:0]  err_sticky,
   output logic [15:0] cycles_done
);

   localparam logic [7:0] L_LONG  = 8'(T_LONG);
   localparam logic [7:0] L_SHORT = 8'(T_SHORT);
   localparam logic [7:0] L_RED   = 8'(2 * T_SHORT);

   // r_vld is low only while r_lamps still holds the reset value rather
   // than a real sample; it gates all checking and tracking.
   logic [4:0]  r_lamps;
   logic        r_vld;
   state_e      r_state;
   logic [2:0]  r_pos;
   logic [7:0]  r_dur;
   logic [2:0]  r_prev_phase;
   logic        r_tim_bad;
   logic [3:0]  r_sticky;
   logic [15:0] r_cycles;

   logic [2:0]  w_phase;
   logic        w_conflict;
   logic        w_changed;
   logic [7:0]  w_dur_next;
   logic [2:0]  w_pos_inc;
   logic [7:0]  w_cur_len;
   state_e      w_state_next;
   logic [2:0]  w_pos_next;
   logic        w_cg_entry;
   logic        w_count;

   traffic_lamp_decode u_decode (
      .i_lamps    (r_lamps),
      .o_phase    (w_phase),
      .o_conflict (w_conflict)
   );

   // Single input sampling stage; every check works on this sample
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lamps <= 5'b00000;
         r_vld   <= 1'b0;
      end else begin
         r_lamps <= {road_red, road_yellow, road_green, ped_red, ped_green};
         r_vld   <= 1'b1;
      end
   end

   // Next tracker state and error pulses for the current sample.
   // r_prev_phase/r_dur describe the display as of the previous sample, so a
   // change is detected here and the previous display's length is judged.
   always_comb begin
      w_changed    = (w_phase != r_prev_phase);
      w_dur_next   = w_changed ? 8'd1 : ((r_dur == 8'hFF) ? r_dur : r_dur + 8'd1);
      w_pos_inc    = (r_pos == POS_LAST) ? 3'd0 : r_pos + 3'd1;
      w_cur_len    = exp_len(r_pos, L_LONG, L_SHORT, L_RED);
      w_state_next = r_state;
      w_pos_next   = r_pos;
      w_cg_entry   = 1'b0;
      w_count      = 1'b0;
      err_conflict = 1'b0;
      err_invalid  = 1'b0;
      err_sequence = 1'b0;
      err_timing   = 1'b0;
      if (r_vld) begin
         err_conflict = w_conflict;
         err_invalid  = (w_phase == PH_INVALID);
         case (r_state)
            ST_SYNC: begin
               // The reset value of r_prev_phase is INVALID, so a first
               // sample of CG also counts as a change into CG.
               if (w_changed && (w_phase == PH_CG)) begin
                  w_state_next = ST_LOCK;
                  w_pos_next   = 3'd0;
                  w_cg_entry   = 1'b1;
               end
            end
            ST_LOCK: begin
               // Too short on leaving a display, or one pulse on overrun
               if (w_changed && (r_dur < w_cur_len)) begin
                  err_timing = 1'b1;
               end else if (!w_changed && (w_dur_next == w_cur_len + 8'd1)) begin
                  err_timing = 1'b1;
               end
               if (w_phase == PH_INVALID) begin
                  w_state_next = ST_SYNC;
               end else if (w_changed) begin
                  if (w_phase != exp_phase(w_pos_inc)) begin
                     err_sequence = 1'b1;
                     w_state_next = ST_SYNC;
                  end else begin
                     w_pos_next = w_pos_inc;
                     if (w_phase == PH_CG) begin
                        w_cg_entry = 1'b1;
                        w_count    = !r_tim_bad && !err_timing;
                     end
                  end
               end
            end
            default: w_state_next = ST_SYNC;
         endcase
      end
   end

   // Tracker state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_SYNC;
         r_pos        <= 3'd0;
         r_dur        <= 8'd0;
         r_prev_phase <= PH_INVALID;
      end else if (r_vld) begin
         r_state      <= w_state_next;
         r_pos        <= w_pos_next;
         r_dur        <= w_dur_next;
         r_prev_phase <= w_phase;
      end
   end

   // Per-cycle timing-error memory, sticky flags and validated-cycle count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tim_bad <= 1'b0;
         r_sticky  <= 4'b0000;
         r_cycles  <= 16'd0;
      end else begin
         if (w_cg_entry) begin
            r_tim_bad <= 1'b0;
         end else if (err_timing) begin
            r_tim_bad <= 1'b1;
         end
         // A pulse arriving with clr_err wins so no event is lost
         r_sticky <= (clr_err ? 4'b0000 : r_sticky) |
                     {err_timing, err_sequence, err_invalid, err_conflict};
         if (w_count && (r_cycles != 16'hFFFF)) begin
            r_cycles <= r_cycles + 16'd1;
         end
      end
   end

   assign phase       = w_phase;
   assign locked      = (r_state == ST_LOCK);
   assign err_sticky  = r_sticky;
   assign cycles_done = r_cycles;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: vector tables of lamp samples with the
// expected phase/pulses, plus checkpoints for locked, sticky flags and count.
module tb_traffic_lamp_monitor;

  localparam logic [4:0] L_CG   = 5'b00110;
  localparam logic [4:0] L_CY   = 5'b01010;
  localparam logic [4:0] L_RH   = 5'b10010;
  localparam logic [4:0] L_PG   = 5'b10001;
  localparam logic [4:0] L_CRY  = 5'b11010;
  localparam logic [4:0] L_CONF = 5'b10101;

  localparam logic [2:0] P_CG  = 3'd0;
  localparam logic [2:0] P_CY  = 3'd1;
  localparam logic [2:0] P_RH  = 3'd2;
  localparam logic [2:0] P_PG  = 3'd3;
  localparam logic [2:0] P_CRY = 3'd4;
  localparam logic [2:0] P_INV = 3'd7;

  // pulse = {timing, sequence, invalid, conflict} for this sample.
  // When chk is set, lk/st/cy are checked after the sample is applied; they
  // then reflect processing up to the previous sample.
  typedef struct packed {
    logic [4:0]  lamps;
    logic        clr;
    logic [2:0]  ph;
    logic [3:0]  pulse;
    logic        chk;
    logic        lk;
    logic [3:0]  st;
    logic [15:0] cy;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        road_red, road_yellow, road_green, ped_red, ped_green;
  logic        clr_err;
  logic [2:0]  phase;
  logic        locked;
  logic        err_conflict, err_invalid, err_sequence, err_timing;
  logic [3:0]  err_sticky;
  logic [15:0] cycles_done;

  vec_t       tbl[$];
  logic [6:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  traffic_lamp_monitor #(.T_LONG(6), .T_SHORT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .road_red     (road_red),
    .road_yellow  (road_yellow),
    .road_green   (road_green),
    .ped_red      (ped_red),
    .ped_green    (ped_green),
    .clr_err      (clr_err),
    .phase        (phase),
    .locked       (locked),
    .err_conflict (err_conflict),
    .err_invalid  (err_invalid),
    .err_sequence (err_sequence),
    .err_timing   (err_timing),
    .err_sticky   (err_sticky),
    .cycles_done  (cycles_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // table builders
  task automatic add(input logic [4:0] l, input logic [2:0] ph, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = '0;
      v.lamps = l;
      v.ph = ph;
      tbl.push_back(v);
    end
  endtask

  task automatic pulse_at(input int back, input logic [3:0] p);
    tbl[tbl.size() - 1 - back].pulse = p;
  endtask

  task automatic clr_at(input int back);
    tbl[tbl.size() - 1 - back].clr = 1'b1;
  endtask

  task automatic chk_at(input logic lk, input logic [3:0] st, input logic [15:0] cy);
    tbl[tbl.size() - 1].chk = 1'b1;
    tbl[tbl.size() - 1].lk  = lk;
    tbl[tbl.size() - 1].st  = st;
    tbl[tbl.size() - 1].cy  = cy;
  endtask

  // CY2 RH4 PG6 RH4 CRY2 with no errors
  task automatic add_rest();
    add(L_CY, P_CY, 2);
    add(L_RH, P_RH, 4);
    add(L_PG, P_PG, 6);
    add(L_RH, P_RH, 4);
    add(L_CRY, P_CRY, 2);
  endtask

  // driver + scoreboard: drive at negedge, compare at the following negedge
  task automatic run_table(input string tag);
    logic [6:0] e;
    for (int i = 0; i < tbl.size(); i++) begin
      {road_red, road_yellow, road_green, ped_red, ped_green} = tbl[i].lamps;
      clr_err = tbl[i].clr;
      exp_q.push_back({tbl[i].ph, tbl[i].pulse});
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s phase[%0d]", tag, i), 16'(phase), 16'(e[6:4]));
      check($sformatf("%s pulses[%0d]", tag, i),
            16'({err_timing, err_sequence, err_invalid, err_conflict}), 16'(e[3:0]));
      if (tbl[i].chk) begin
        check($sformatf("%s locked[%0d]", tag, i), 16'(locked), 16'(tbl[i].lk));
        check($sformatf("%s sticky[%0d]", tag, i), 16'(err_sticky), 16'(tbl[i].st));
        check($sformatf("%s cycles[%0d]", tag, i), cycles_done, tbl[i].cy);
      end
    end
    clr_err = 1'b0;
    tbl.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " phase"}, 16'(phase), 16'(P_INV));
    check({tag, " locked"}, 16'(locked), 16'd0);
    check({tag, " pulses"}, 16'({err_timing, err_sequence, err_invalid, err_conflict}), 16'd0);
    check({tag, " sticky"}, 16'(err_sticky), 16'd0);
    check({tag, " cycles"}, cycles_done, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr_err = 1'b0;
    {road_red, road_yellow, road_green, ped_red, ped_green} = 5'b00000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // three legal loops, then CG closes the third loop
    add(L_CG, P_CG, 2); chk_at(1'b1, 4'b0000, 16'd0);
    add(L_CG, P_CG, 4); add_rest();
    for (int k = 0; k < 2; k++) begin
      add(L_CG, P_CG, 6); add_rest();
    end
    add(L_CG, P_CG, 2); chk_at(1'b1, 4'b0000, 16'd3);
    // CG held 8 cycles: one timing pulse at dur 7; clr_err alongside it
    add(L_CG, P_CG, 6); pulse_at(1, 4'b1000); clr_at(0);
    chk_at(1'b1, 4'b1000, 16'd3);
    add(L_CY, P_CY, 1); clr_at(0); chk_at(1'b1, 4'b0000, 16'd3);
    add(L_CY, P_CY, 1);
    add(L_RH, P_RH, 4); add(L_PG, P_PG, 6); add(L_RH, P_RH, 4); add(L_CRY, P_CRY, 2);
    add(L_CG, P_CG, 2); chk_at(1'b1, 4'b0000, 16'd3);
    // the following clean loop counts again
    add(L_CG, P_CG, 4); add_rest();
    add(L_CG, P_CG, 2); chk_at(1'b1, 4'b0000, 16'd4);
    // RH after PG goes straight back to PG: order error, then re-lock on CG
    add(L_CG, P_CG, 4); add(L_CY, P_CY, 2); add(L_RH, P_RH, 4);
    add(L_PG, P_PG, 6); add(L_RH, P_RH, 4);
    add(L_PG, P_PG, 1); pulse_at(0, 4'b0100);
    add(L_PG, P_PG, 1); chk_at(1'b0, 4'b0100, 16'd4);
    add(L_PG, P_PG, 2);
    add(L_CG, P_CG, 2); clr_at(0); chk_at(1'b1, 4'b0000, 16'd4);
    // ped green with road green for 3 cycles
    add(L_CG, P_CG, 4);
    add(L_CONF, P_INV, 3); pulse_at(0, 4'b0011); pulse_at(1, 4'b0011); pulse_at(2, 4'b0011);
    add(L_CG, P_CG, 1); chk_at(1'b0, 4'b0011, 16'd4);
    add(L_CG, P_CG, 1); chk_at(1'b1, 4'b0011, 16'd4);
    // advance into PG for the reset test
    add(L_CG, P_CG, 4); add(L_CY, P_CY, 2); add(L_RH, P_RH, 4); add(L_PG, P_PG, 3);
    run_table("seqA");

    // one reset cycle during PG
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midreset");
    rst_n = 1'b1;

    add(L_PG, P_PG, 2); chk_at(1'b0, 4'b0000, 16'd0);
    add(L_CG, P_CG, 2); chk_at(1'b1, 4'b0000, 16'd0);
    // CY only one cycle long: timing pulse on entering RH
    add(L_CG, P_CG, 4); add(L_CY, P_CY, 1);
    add(L_RH, P_RH, 4); pulse_at(3, 4'b1000);
    add(L_PG, P_PG, 6); add(L_RH, P_RH, 4); add(L_CRY, P_CRY, 2);
    add(L_CG, P_CG, 2); chk_at(1'b1, 4'b1000, 16'd0);
    add(L_CG, P_CG, 4); add_rest();
    add(L_CG, P_CG, 2); chk_at(1'b1, 4'b1000, 16'd1);
    run_table("seqB");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
